// File: rtl/fp_operand_unpack_pkg.sv
// fp_operand_unpack_pkg: shared FPU field widths, special encodings and operand classes.
package fp_operand_unpack_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_O_W  = EXP_W + 2;
    localparam int SH_W     = 5;
    localparam int BIAS     = 127;
    localparam int QNAN_BIT = 22;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_DENORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } cls_e;

endpackage

// File: rtl/fp_operand_unpack_lzc23.sv
// lzc23: combinational leading-zero count of a 23-bit field; all-zero input yields 23.
module lzc23 (
    input  logic [22:0] a_i,
    output logic [4:0]  cnt_o
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        cnt_o = 5'd23;
        for (int i = 0; i < 23; i++)
            if (a_i[i]) cnt_o = 5'(22 - i);
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: two-stage valid/ready pipeline that classifies an IEEE-754 single
// operand and pre-normalises denormals so the significand always carries a leading 1.
module fp_operand_unpack
    import fp_operand_unpack_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic [EXP_O_W-1:0]       out_exp,
    output logic [MAN_W:0]           out_sig,
    output logic [SH_W-1:0]          required_shift,
    output logic                     is_zero,
    output logic                     is_denorm,
    output logic                     is_inf,
    output logic                     is_qnan,
    output logic                     is_snan
);

    logic               s1_valid_q, s1_sign_q;
    logic [EXP_W-1:0]   s1_exp_q;
    logic [MAN_W-1:0]   s1_man_q;
    logic [SH_W-1:0]    s1_lz_q, lz_d;
    cls_e               s1_cls_q, cls_d, s2_cls_q;
    logic               s2_valid_q, s2_sign_q;
    logic [EXP_O_W-1:0] s2_exp_q, exp_d;
    logic [MAN_W:0]     s2_sig_q, sig_d;
    logic [SH_W-1:0]    s2_shift_q, shift_d, sh;
    logic [MAN_W-1:0]   shifted;
    logic [EXP_W-1:0]   e;
    logic [MAN_W-1:0]   m;
    logic               s1_load, s2_load, special;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_load  = in_valid && in_ready;

    assign e = in_word[30:23];
    assign m = in_word[22:0];

    lzc23 u_lzc (.a_i(m), .cnt_o(lz_d));

    always_comb begin
        cls_d = CLS_NORMAL;
        if (e == EXP_MAX)
            cls_d = (m == '0) ? CLS_INF : (m[QNAN_BIT] ? CLS_QNAN : CLS_SNAN);
        else if (e == '0)
            cls_d = (m == '0) ? CLS_ZERO : CLS_DENORM;
    end

    // Shifting by lz+1 pushes the leading one out of the field into the hidden bit.
    assign sh      = s1_lz_q + 5'd1;
    assign shifted = s1_man_q << sh;
    assign special = s1_cls_q inside {CLS_INF, CLS_QNAN, CLS_SNAN};

    always_comb begin
        sig_d   = {1'b1, s1_man_q};
        exp_d   = EXP_O_W'(s1_exp_q);
        shift_d = '0;
        if (s1_cls_q == CLS_DENORM) begin
            sig_d   = {1'b1, shifted};
            exp_d   = EXP_O_W'(1) - EXP_O_W'(sh);
            shift_d = sh;
        end else if (special) begin
            sig_d = {1'b0, s1_man_q};
            exp_d = EXP_O_W'(EXP_MAX);
        end else if (s1_cls_q == CLS_ZERO) begin
            sig_d = '0;
            exp_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s1_lz_q    <= '0;
            s1_cls_q   <= CLS_NORMAL;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_sig_q   <= '0;
            s2_shift_q <= '0;
            s2_cls_q   <= CLS_NORMAL;
        end else begin
            if (s1_load) begin
                s1_sign_q <= in_word[31];
                s1_exp_q  <= e;
                s1_man_q  <= m;
                s1_lz_q   <= lz_d;
                s1_cls_q  <= cls_d;
            end
            s1_valid_q <= s1_load || (s1_valid_q && !s2_load);
            if (s2_load) begin
                s2_sign_q  <= s1_sign_q;
                s2_exp_q   <= exp_d;
                s2_sig_q   <= sig_d;
                s2_shift_q <= shift_d;
                s2_cls_q   <= s1_cls_q;
            end
            s2_valid_q <= s2_load || (s2_valid_q && !out_ready);
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_sign       = s2_sign_q;
    assign out_exp        = s2_exp_q;
    assign out_sig        = s2_sig_q;
    assign required_shift = s2_shift_q;
    assign is_zero        = s2_cls_q == CLS_ZERO;
    assign is_denorm      = s2_cls_q == CLS_DENORM;
    assign is_inf         = s2_cls_q == CLS_INF;
    assign is_qnan        = s2_cls_q == CLS_QNAN;
    assign is_snan        = s2_cls_q == CLS_SNAN;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// tb_fp_operand_unpack: randomized and directed checks against an IEEE-754 reference model.
module tb_fp_operand_unpack;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_sig;
    logic [4:0]  required_shift;
    logic        is_zero, is_denorm, is_inf, is_qnan, is_snan;
    logic [44:0] obs;
    int          checks = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    fp_operand_unpack dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
        .required_shift(required_shift),
        .is_zero(is_zero), .is_denorm(is_denorm), .is_inf(is_inf),
        .is_qnan(is_qnan), .is_snan(is_snan)
    );

    assign obs = {out_sign, out_exp, out_sig, required_shift,
                  is_zero, is_denorm, is_inf, is_qnan, is_snan};

    // {sign, exp10, sig24, shift5, flags{zero,denorm,inf,qnan,snan}}
    function automatic logic [44:0] model(input logic [31:0] w);
        int e, m, ex, sg, sh, p;
        logic [4:0] fl;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        sh = 0;
        if (e == 255) begin
            ex = 255; sg = m;
            fl = (m == 0) ? 5'b00100 : (m >= (1 << 22)) ? 5'b00010 : 5'b00001;
        end else if (e == 0 && m == 0) begin
            ex = 0; sg = 0; fl = 5'b10000;
        end else if (e == 0) begin
            p = 0;
            for (int b = 0; b < 23; b++) if ((m >> b) & 1) p = b;
            sh = 23 - p;
            sg = m * (1 << sh);
            ex = 1 - sh;
            fl = 5'b01000;
        end else begin
            ex = e; sg = m + (1 << 23); fl = 5'b00000;
        end
        return {w[31], 10'(ex), 24'(sg), 5'(sh), fl};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0: e = 8'h00;
            1: e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e, 23'($urandom >> $urandom_range(0, 31))};
    endfunction

    task automatic test_reset();
        logic [44:0] want;
        want = {1'b0, 10'h07F, 24'h800000, 5'd0, 5'b00000};
        RST = 1'b0; in_valid = 1'b1; in_word = 32'h3F800000; out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", obs);
        end
        RST = 1'b1;
        @(posedge CLK); #1 in_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_latency_early: out_valid=%b want 0", out_valid);
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || obs !== want) begin
            failures++;
            $display("FAIL reset_first_word: valid=%b got %h want %h", out_valid, obs, want);
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_single_output: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_one(input string name, input logic [31:0] w, input logic [44:0] want);
        @(posedge CLK); #1 in_valid = 1'b1; in_word = w; out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        @(posedge CLK); #1 in_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || obs !== want) begin
            failures++;
            $display("FAIL %s: valid=%b got %h want %h", name, out_valid, obs, want);
        end
    endtask

    task automatic test_denorm();
        test_one("denorm_0x00400000", 32'h00400000, {1'b0, 10'h000, 24'h800000, 5'd1, 5'b01000});
        test_one("denorm_0x00000001", 32'h00000001, {1'b0, 10'h3EA, 24'h800000, 5'd23, 5'b01000});
        test_one("denorm_0x80012345", 32'h80012345, model(32'h80012345));
    endtask

    task automatic test_specials();
        test_one("inf", 32'h7F800000, {1'b0, 10'h0FF, 24'h000000, 5'd0, 5'b00100});
        test_one("qnan", 32'hFFC00001, {1'b1, 10'h0FF, 24'h400001, 5'd0, 5'b00010});
        test_one("snan", 32'h7F800001, {1'b0, 10'h0FF, 24'h000001, 5'd0, 5'b00001});
        test_one("neg_zero", 32'h80000000, {1'b1, 10'h000, 24'h000000, 5'd0, 5'b10000});
        test_one("normal_max", 32'h7F7FFFFF, {1'b0, 10'h0FE, 24'hFFFFFF, 5'd0, 5'b00000});
    endtask

    task automatic test_backpressure();
        logic [31:0] w[4];
        int acc = 0, got = 0, first = -1, last = -1;
        for (int i = 0; i < 4; i++) w[i] = rand_word();
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            out_ready = 1'b0;
            in_valid = acc < 4;
            in_word = w[acc < 4 ? acc : 3];
            @(negedge CLK);
            if (out_valid) begin
                checks++;
                if (obs !== model(w[0])) begin
                    failures++;
                    $display("FAIL bp_hold: cycle %0d got %h want %h", c, obs, model(w[0]));
                end
            end
            if (in_valid && in_ready) acc++;
        end
        checks++;
        if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall: accepted=%0d in_ready=%b out_valid=%b want 2/0/1", acc, in_ready, out_valid);
        end
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(posedge CLK); #1;
            out_ready = 1'b1;
            in_valid = acc < 4;
            in_word = w[acc < 4 ? acc : 3];
            @(negedge CLK);
            if (out_valid && out_ready) begin
                checks++;
                if (obs !== model(w[got])) begin
                    failures++;
                    $display("FAIL bp_drain_%0d: got %h want %h", got, obs, model(w[got]));
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (in_valid && in_ready) acc++;
        end
        @(posedge CLK); #1 in_valid = 1'b0;
        checks++;
        if (got != 4 || last - first != 3) begin
            failures++;
            $display("FAIL bp_drain_count: outputs=%0d span=%0d want 4/3", got, last - first);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_throughput();
        logic [31:0] qw[$];
        int qc[$];
        int sent = 0, recv = 0;
        logic [31:0] w;
        int c0;
        for (int c = 0; c < 120; c++) begin
            @(posedge CLK); #1;
            out_ready = 1'b1;
            in_valid = sent < 100;
            in_word = rand_word();
            @(negedge CLK);
            if (out_valid) begin
                checks++;
                if (qw.size() == 0) begin
                    failures++;
                    $display("FAIL tp_spurious: cycle %0d got %h want no output", c, obs);
                end else begin
                    w = qw.pop_front();
                    c0 = qc.pop_front();
                    recv++;
                    if (obs !== model(w) || c - c0 != 2) begin
                        failures++;
                        $display("FAIL tp_word_%0d: in %h got %h want %h latency %0d want 2",
                                 recv, w, obs, model(w), c - c0);
                    end
                end
            end
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL tp_in_ready: cycle %0d got %b want 1", c, in_ready);
                end else begin
                    qw.push_back(in_word);
                    qc.push_back(c);
                    sent++;
                end
            end
        end
        @(posedge CLK); #1 in_valid = 1'b0;
        checks++;
        if (recv != 100 || qw.size() != 0) begin
            failures++;
            $display("FAIL tp_count: received %0d want 100", recv);
        end
    endtask

    task automatic test_async_reset();
        @(posedge CLK); #1 in_valid = 1'b1; in_word = rand_word(); out_ready = 1'b1;
        @(posedge CLK); #1 in_word = rand_word();
        @(posedge CLK); #1 in_valid = 1'b1; in_word = rand_word(); out_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ar_in_flight: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
            failures++;
            $display("FAIL ar_immediate: out_valid=%b in_ready=%b data=%h want 0/1/0", out_valid, in_ready, obs);
        end
        @(negedge CLK); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK); RST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL ar_stale: cycle %0d out_valid=%b want 0", c, out_valid);
            end
        end
        test_one("ar_after", 32'hC0490FDB, {1'b1, 10'h080, 24'hC90FDB, 5'd0, 5'b00000});
    endtask

    initial begin
        test_reset();
        test_denorm();
        test_specials();
        test_backpressure();
        test_throughput();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
